// File: rtl/uart_rxd.sv
// UART 8N1 receiver: synchronised serial input, mid-bit sampling,
// one-cycle valid strobe per good byte and a framing-error strobe.
module uart_rxd #(
    parameter int CLKS_PER_BIT = 434,
    parameter int CNT_W        = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_rs232_rxd,
    output logic [7:0] o_data,
    output logic       o_rx_valid,
    output logic       o_frame_err,
    output logic       o_rx_busy
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] bit_cnt, cnt_n;
    logic [2:0]       idx, idx_n;
    logic [7:0]       shreg, shreg_n;
    logic [7:0]       data_n;
    logic             valid_n, ferr_n;
    logic             rxd_m, rxd_s, rxd_d;
    logic             fall;

    // Idle-high reset keeps a quiet line from looking like an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
            rxd_d <= 1'b1;
        end else begin
            rxd_m <= i_rs232_rxd;
            rxd_s <= rxd_m;
            rxd_d <= rxd_s;
        end
    end

    assign fall      = rxd_d & ~rxd_s;
    assign o_rx_busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            idx         <= '0;
            shreg       <= '0;
            o_data      <= '0;
            o_rx_valid  <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            state       <= state_n;
            bit_cnt     <= cnt_n;
            idx         <= idx_n;
            shreg       <= shreg_n;
            o_data      <= data_n;
            o_rx_valid  <= valid_n;
            o_frame_err <= ferr_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = bit_cnt;
        idx_n   = idx;
        shreg_n = shreg;
        data_n  = o_data;
        valid_n = 1'b0;
        ferr_n  = 1'b0;
        unique case (state)
            IDLE: begin
                if (fall) begin
                    state_n = START;
                    cnt_n   = '0;
                end
            end
            START: begin
                if (bit_cnt == HALF) begin
                    cnt_n   = '0;
                    idx_n   = '0;
                    state_n = rxd_s ? IDLE : DATA;
                end else begin
                    cnt_n = bit_cnt + 1'b1;
                end
            end
            DATA: begin
                if (bit_cnt == LAST) begin
                    cnt_n          = '0;
                    shreg_n[idx]   = rxd_s;
                    if (idx == 3'd7) begin
                        state_n = STOP;
                    end else begin
                        idx_n = idx + 3'd1;
                    end
                end else begin
                    cnt_n = bit_cnt + 1'b1;
                end
            end
            STOP: begin
                if (bit_cnt == LAST) begin
                    cnt_n = '0;
                    if (rxd_s) begin
                        data_n  = shreg;
                        valid_n = 1'b1;
                        state_n = IDLE;
                    end else begin
                        ferr_n  = 1'b1;
                        state_n = BREAK;
                    end
                end else begin
                    cnt_n = bit_cnt + 1'b1;
                end
            end
            // Hold off until the line returns high after a bad stop bit.
            BREAK: begin
                if (rxd_s) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule
